mprj_io_ctrl: RTL and testbench
===============================

# mprj_io_ctrl

Per-pad configuration and signal-steering stage directly upstream of the user-project GPIO pad array. Holds a shadow and an active 13-bit configuration word for each pad and drives the pad-side configuration buses (`oeb`, `inp_dis`, `dm`, …) from the active words. Steers each pad's output and output-enable between the management SoC and the user project. Shadow-to-active commits are staggered one pad per cycle to limit simultaneous pad switching.

## Interface
- PADS, 38 (`MPRJ_IO_PADS`), number of pads
- CFG_W, 13, configuration word width (fixed by package)
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- cfg_we  in  1  shadow write strobe
- cfg_addr  in  6  pad index for write/read
- cfg_wdata  in  13  shadow write data
- cfg_rdata  out  13  shadow word at cfg_addr; combinational; 0 if cfg_addr ≥ PADS
- cfg_ready  out  1  equals !busy
- cfg_apply  in  1  start shadow→active commit
- busy  out  1  commit in progress
- apply_done  out  1  one-cycle pulse when commit completes
- mgmt_io_out, user_io_out, user_io_oeb  in  PADS  output data/enable sources
- io_in  in  PADS  from pad array
- mgmt_io_in, user_io_in  out  PADS  steered inputs
- io_out, oeb, inp_dis, ib_mode_sel, vtrip_sel, slow_sel, holdover, analog_en, analog_sel, analog_pol  out  PADS  to pad array
- dm  out  3*PADS  drive mode; pad i uses dm[3i+2:3i]

## Operation
- Word layout: [0] mgmt_ena, [1] oeb, [2] hold_ovr, [3] inp_dis, [4] ib_mode_sel, [5] analog_en, [6] analog_sel, [7] analog_pol, [8] slow_sel, [9] vtrip_sel, [12:10] dm.
- CFG_DEFAULT = 13'h0403: mgmt_ena=1, oeb=1, dm=3'b001, all other fields 0.
- Shadow write: takes effect when cfg_we=1 and cfg_ready=1 and cfg_addr < PADS. Otherwise the write is dropped. Writes while busy are dropped.
- Commit FSM has two states.
  - IDLE: if cfg_apply=1, go to RUN with idx=0.
  - RUN: copy shadow[idx] to active[idx] each cycle and increment idx. After idx = PADS-1 is copied, go to IDLE and pulse apply_done.
- cfg_apply while busy is ignored.
- Pad-side config outputs come combinationally from the active word fields.
- io_out[i] = mgmt_ena ? mgmt_io_out[i] : user_io_out[i].
- oeb[i] = mgmt_ena ? active oeb bit : user_io_oeb[i].
- mgmt_io_in = io_in, always.
- user_io_in[i] = mgmt_ena ? 0 : io_in[i].

## Timing
- Reset:
  - Shadow and active words go to CFG_DEFAULT.
  - FSM goes to IDLE, busy=0, apply_done=0, cfg_ready=1.
  - Resulting pad outputs: io_out=mgmt_io_out, oeb=all 1, dm=001 per pad, all other configuration outputs 0.
- Reset during RUN aborts the commit immediately. No partial state survives; active words return to default.
- Commit timing: cfg_apply is sampled at edge E0. busy=1 after E0. Pad k's active word updates at edge E(k+1). busy=0 and apply_done=1 after E(PADS), for exactly one cycle.
  - A commit takes PADS cycles.
  - Back-to-back apply is accepted in the apply_done cycle.
- A write and an apply in the same IDLE cycle: the write lands in shadow at E0 and is included in the commit.
- Read-during-write returns the old shadow value (register read, combinational mux).
- No arithmetic beyond idx, which is a 6-bit counter. idx never exceeds PADS-1.

## Structure
- Package `mprj_io_pkg` holds:
  - CFG_W
  - field index localparams (CFG_MGMT_ENA … CFG_DM_LSB)
  - CFG_DEFAULT
  - the FSM state enum (IDLE, RUN)
- Sub-module `mprj_io_cfg_cell`, instantiated PADS times, contains:
  - one shadow register and one active register
  - write enable and commit enable inputs
  - the output/oeb/input steering
- The top level holds the address decode, the commit FSM/counter and the cfg_rdata mux.

## Test plan
- Reset, then idle: oeb=all 1, dm[2:0]=001 for pad 0, io_out follows mgmt_io_out, user_io_in=0, cfg_rdata(addr 5)=13'h0403.
- Write 13'h1800 (user, oeb=0, dm=110) to pad 7, then apply:
  - busy for 38 cycles
  - pad 7 switches to user_io_out/user_io_oeb at edge E8
  - apply_done pulses after E38
  - user_io_in[7]=io_in[7]
- Write to pads 0 and 37 during busy: dropped; cfg_rdata unchanged.
- Write to cfg_addr=40: ignored; cfg_rdata(40)=0.
- Write and apply in the same cycle: the new value appears on pad 0 at E1.
- Assert wb_rst_i at RUN cycle 10: busy=0 next cycle, all pads back to defaults, no apply_done pulse.

Source files
------------

// File: rtl/mprj_io_pkg.sv
// Shared definitions for the GPIO pad configuration stage: word layout,
// reset configuration and commit FSM state encoding.
package mprj_io_pkg;

    localparam int MPRJ_IO_PADS = 38;
    localparam int CFG_W        = 13;

    // Bit positions inside a pad configuration word
    localparam int CFG_MGMT_ENA    = 0;
    localparam int CFG_OEB         = 1;
    localparam int CFG_HOLD_OVR    = 2;
    localparam int CFG_INP_DIS     = 3;
    localparam int CFG_IB_MODE_SEL = 4;
    localparam int CFG_ANALOG_EN   = 5;
    localparam int CFG_ANALOG_SEL  = 6;
    localparam int CFG_ANALOG_POL  = 7;
    localparam int CFG_SLOW_SEL    = 8;
    localparam int CFG_VTRIP_SEL   = 9;
    localparam int CFG_DM_LSB      = 10;

    // Management-owned, output disabled, dm=001
    localparam logic [CFG_W-1:0] CFG_DEFAULT = 13'h0403;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } commit_state_t;

    // Extract the 3-bit drive mode field from a configuration word
    function automatic logic [2:0] cfg_dm(input logic [CFG_W-1:0] word);
        return word[CFG_DM_LSB +: 3];
    endfunction

endpackage

// File: rtl/mprj_io_cfg_cell.sv
// One pad: shadow/active configuration registers plus output, enable and
// input steering between the management SoC and the user project.
module mprj_io_cfg_cell
    import mprj_io_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             commit,
    input  logic [CFG_W-1:0] wdata,
    input  logic             mgmt_io_out,
    input  logic             user_io_out,
    input  logic             user_io_oeb,
    input  logic             io_in,
    output logic [CFG_W-1:0] shadow,
    output logic             io_out,
    output logic             oeb,
    output logic             inp_dis,
    output logic             ib_mode_sel,
    output logic             vtrip_sel,
    output logic             slow_sel,
    output logic             holdover,
    output logic             analog_en,
    output logic             analog_sel,
    output logic             analog_pol,
    output logic [2:0]       dm,
    output logic             mgmt_io_in,
    output logic             user_io_in
);

    logic [CFG_W-1:0] shadow_r;
    logic [CFG_W-1:0] active_r;
    logic             mgmt_ena_s;

    // Shadow takes software writes; active takes the shadow on its commit slot
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_r <= CFG_DEFAULT;
            active_r <= CFG_DEFAULT;
        end else begin
            if (we) begin
                shadow_r <= wdata;
            end
            if (commit) begin
                active_r <= shadow_r;
            end
        end
    end

    assign shadow     = shadow_r;
    assign mgmt_ena_s = active_r[CFG_MGMT_ENA];

    // Static pad configuration fields straight from the active word
    always_comb begin
        holdover    = active_r[CFG_HOLD_OVR];
        inp_dis     = active_r[CFG_INP_DIS];
        ib_mode_sel = active_r[CFG_IB_MODE_SEL];
        analog_en   = active_r[CFG_ANALOG_EN];
        analog_sel  = active_r[CFG_ANALOG_SEL];
        analog_pol  = active_r[CFG_ANALOG_POL];
        slow_sel    = active_r[CFG_SLOW_SEL];
        vtrip_sel   = active_r[CFG_VTRIP_SEL];
        dm          = cfg_dm(active_r);
    end

    // Steer data/enable out and gate the user-side input by pad ownership
    always_comb begin
        io_out     = user_io_out;
        oeb        = user_io_oeb;
        user_io_in = io_in;
        mgmt_io_in = io_in;
        if (mgmt_ena_s) begin
            io_out     = mgmt_io_out;
            oeb        = active_r[CFG_OEB];
            user_io_in = 1'b0;
        end else begin
            io_out     = user_io_out;
            oeb        = user_io_oeb;
            user_io_in = io_in;
        end
    end

endmodule

// File: rtl/mprj_io_ctrl.sv
// GPIO pad configuration controller: shadow write decode, staggered
// one-pad-per-cycle shadow-to-active commit, and shadow readback.
module mprj_io_ctrl
    import mprj_io_pkg::*;
#(
    parameter int PADS = MPRJ_IO_PADS
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              cfg_we,
    input  logic [5:0]        cfg_addr,
    input  logic [CFG_W-1:0]  cfg_wdata,
    output logic [CFG_W-1:0]  cfg_rdata,
    output logic              cfg_ready,
    input  logic              cfg_apply,
    output logic              busy,
    output logic              apply_done,
    input  logic [PADS-1:0]   mgmt_io_out,
    input  logic [PADS-1:0]   user_io_out,
    input  logic [PADS-1:0]   user_io_oeb,
    input  logic [PADS-1:0]   io_in,
    output logic [PADS-1:0]   mgmt_io_in,
    output logic [PADS-1:0]   user_io_in,
    output logic [PADS-1:0]   io_out,
    output logic [PADS-1:0]   oeb,
    output logic [PADS-1:0]   inp_dis,
    output logic [PADS-1:0]   ib_mode_sel,
    output logic [PADS-1:0]   vtrip_sel,
    output logic [PADS-1:0]   slow_sel,
    output logic [PADS-1:0]   holdover,
    output logic [PADS-1:0]   analog_en,
    output logic [PADS-1:0]   analog_sel,
    output logic [PADS-1:0]   analog_pol,
    output logic [3*PADS-1:0] dm
);

    localparam logic [5:0] PADS_L   = 6'(PADS);
    localparam logic [5:0] LAST_IDX = 6'(PADS - 1);

    commit_state_t    state_r;
    commit_state_t    state_s;
    logic [5:0]       idx_r;
    logic [5:0]       idx_s;
    logic             done_r;
    logic             done_s;
    logic             wr_ok_s;
    logic [PADS-1:0]  we_s;
    logic [PADS-1:0]  commit_s;
    logic [CFG_W-1:0] shadow_s [PADS];

    assign busy       = (state_r == RUN);
    assign cfg_ready  = ~busy;
    assign apply_done = done_r;
    assign wr_ok_s    = cfg_we & cfg_ready & (cfg_addr < PADS_L);

    // Commit FSM state, pad index and completion pulse registers
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_r <= IDLE;
            idx_r   <= 6'd0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic: walk idx from 0 to the last pad, then pulse done
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        done_s  = 1'b0;
        case (state_r)
            IDLE: begin
                idx_s = 6'd0;
                if (cfg_apply) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (idx_r == LAST_IDX) begin
                    state_s = IDLE;
                    idx_s   = 6'd0;
                    done_s  = 1'b1;
                end else begin
                    state_s = RUN;
                    idx_s   = idx_r + 6'd1;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = 6'd0;
            end
        endcase
    end

    // Shadow readback: out-of-range addresses read as zero
    always_comb begin
        cfg_rdata = {CFG_W{1'b0}};
        if (cfg_addr < PADS_L) begin
            cfg_rdata = shadow_s[cfg_addr];
        end else begin
            cfg_rdata = {CFG_W{1'b0}};
        end
    end

    for (genvar i = 0; i < PADS; i++) begin : g_pad
        assign we_s[i]     = wr_ok_s & (cfg_addr == 6'(i));
        assign commit_s[i] = busy & (idx_r == 6'(i));

        mprj_io_cfg_cell u_cell (
            .clk         (wb_clk_i),
            .rst         (wb_rst_i),
            .we          (we_s[i]),
            .commit      (commit_s[i]),
            .wdata       (cfg_wdata),
            .mgmt_io_out (mgmt_io_out[i]),
            .user_io_out (user_io_out[i]),
            .user_io_oeb (user_io_oeb[i]),
            .io_in       (io_in[i]),
            .shadow      (shadow_s[i]),
            .io_out      (io_out[i]),
            .oeb         (oeb[i]),
            .inp_dis     (inp_dis[i]),
            .ib_mode_sel (ib_mode_sel[i]),
            .vtrip_sel   (vtrip_sel[i]),
            .slow_sel    (slow_sel[i]),
            .holdover    (holdover[i]),
            .analog_en   (analog_en[i]),
            .analog_sel  (analog_sel[i]),
            .analog_pol  (analog_pol[i]),
            .dm          (dm[3*i +: 3]),
            .mgmt_io_in  (mgmt_io_in[i]),
            .user_io_in  (user_io_in[i])
        );
    end

endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Self-checking bench for mprj_io_ctrl: directed scenarios plus random
// traffic compared every cycle against a timeline-based reference model.
module tb_mprj_io_ctrl;

    localparam int P = 38;

    logic           wb_clk_i = 1'b0;
    logic           wb_rst_i;
    logic           cfg_we;
    logic [5:0]     cfg_addr;
    logic [12:0]    cfg_wdata;
    logic [12:0]    cfg_rdata;
    logic           cfg_ready;
    logic           cfg_apply;
    logic           busy;
    logic           apply_done;
    logic [P-1:0]   mgmt_io_out, user_io_out, user_io_oeb, io_in;
    logic [P-1:0]   mgmt_io_in, user_io_in, io_out, oeb, inp_dis, ib_mode_sel;
    logic [P-1:0]   vtrip_sel, slow_sel, holdover, analog_en, analog_sel, analog_pol;
    logic [3*P-1:0] dm;

    always #5 wb_clk_i = ~wb_clk_i;

    mprj_io_ctrl dut (
        .wb_clk_i    (wb_clk_i),
        .wb_rst_i    (wb_rst_i),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_wdata   (cfg_wdata),
        .cfg_rdata   (cfg_rdata),
        .cfg_ready   (cfg_ready),
        .cfg_apply   (cfg_apply),
        .busy        (busy),
        .apply_done  (apply_done),
        .mgmt_io_out (mgmt_io_out),
        .user_io_out (user_io_out),
        .user_io_oeb (user_io_oeb),
        .io_in       (io_in),
        .mgmt_io_in  (mgmt_io_in),
        .user_io_in  (user_io_in),
        .io_out      (io_out),
        .oeb         (oeb),
        .inp_dis     (inp_dis),
        .ib_mode_sel (ib_mode_sel),
        .vtrip_sel   (vtrip_sel),
        .slow_sel    (slow_sel),
        .holdover    (holdover),
        .analog_en   (analog_en),
        .analog_sel  (analog_sel),
        .analog_pol  (analog_pol),
        .dm          (dm)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register contents plus the edge number at which the
    // current commit was accepted; pad k lands k+1 edges after acceptance.
    logic [12:0] m_shadow [P];
    logic [12:0] m_active [P];
    int          n  = 0;
    int          e0 = -1000;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        int rel;
        n++;
        if (wb_rst_i) begin
            for (int i = 0; i < P; i++) begin
                m_shadow[i] = 13'h0403;
                m_active[i] = 13'h0403;
            end
            e0 = -1000;
        end else begin
            rel = n - 1 - e0;
            if (rel >= 0 && rel <= P - 1) begin
                m_active[rel] = m_shadow[rel];
            end else begin
                if (cfg_we && int'(cfg_addr) < P) m_shadow[cfg_addr] = cfg_wdata;
                if (cfg_apply) e0 = n;
            end
        end
    endtask

    task automatic compare_all();
        logic [P-1:0]   e_out, e_oeb, e_uin, e_hold, e_idis, e_ib, e_aen, e_asel, e_apol, e_slow, e_vtrip;
        logic [3*P-1:0] e_dm;
        logic [12:0]    w, e_rd;
        int             rel;
        for (int i = 0; i < P; i++) begin
            w = m_active[i];
            e_out[i]   = w[0] ? mgmt_io_out[i] : user_io_out[i];
            e_oeb[i]   = w[0] ? w[1] : user_io_oeb[i];
            e_uin[i]   = w[0] ? 1'b0 : io_in[i];
            e_hold[i]  = w[2];
            e_idis[i]  = w[3];
            e_ib[i]    = w[4];
            e_aen[i]   = w[5];
            e_asel[i]  = w[6];
            e_apol[i]  = w[7];
            e_slow[i]  = w[8];
            e_vtrip[i] = w[9];
            e_dm[3*i +: 3] = w[12:10];
        end
        e_rd = (int'(cfg_addr) < P) ? m_shadow[cfg_addr] : 13'h0000;
        rel  = n - e0;
        check_eq("busy",        128'(busy),        128'(rel >= 0 && rel <= P - 1));
        check_eq("cfg_ready",   128'(cfg_ready),   128'(!(rel >= 0 && rel <= P - 1)));
        check_eq("apply_done",  128'(apply_done),  128'(rel == P));
        check_eq("cfg_rdata",   128'(cfg_rdata),   128'(e_rd));
        check_eq("io_out",      128'(io_out),      128'(e_out));
        check_eq("oeb",         128'(oeb),         128'(e_oeb));
        check_eq("mgmt_io_in",  128'(mgmt_io_in),  128'(io_in));
        check_eq("user_io_in",  128'(user_io_in),  128'(e_uin));
        check_eq("holdover",    128'(holdover),    128'(e_hold));
        check_eq("inp_dis",     128'(inp_dis),     128'(e_idis));
        check_eq("ib_mode_sel", 128'(ib_mode_sel), 128'(e_ib));
        check_eq("analog_en",   128'(analog_en),   128'(e_aen));
        check_eq("analog_sel",  128'(analog_sel),  128'(e_asel));
        check_eq("analog_pol",  128'(analog_pol),  128'(e_apol));
        check_eq("slow_sel",    128'(slow_sel),    128'(e_slow));
        check_eq("vtrip_sel",   128'(vtrip_sel),   128'(e_vtrip));
        check_eq("dm",          128'(dm),          128'(e_dm));
    endtask

    // One clock: model consumes the inputs seen at the edge, DUT sampled 1ns later
    task automatic step();
        @(posedge wb_clk_i);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic rand_io();
        mgmt_io_out = P'({$urandom(), $urandom()});
        user_io_out = P'({$urandom(), $urandom()});
        user_io_oeb = P'({$urandom(), $urandom()});
        io_in       = P'({$urandom(), $urandom()});
    endtask

    int bcnt;
    int dcnt;

    initial begin
        wb_rst_i  = 1'b1;
        cfg_we    = 1'b0;
        cfg_addr  = 6'd5;
        cfg_wdata = 13'h0000;
        cfg_apply = 1'b0;
        rand_io();
        @(negedge wb_clk_i);
        step();
        step();
        wb_rst_i = 1'b0;

        // Idle after reset: management owns every pad with default config
        step();
        check_eq("rst_rdata5", 128'(cfg_rdata), 128'(13'h0403));
        check_eq("rst_oeb",    128'(oeb),       128'({P{1'b1}}));
        check_eq("rst_dm0",    128'(dm[2:0]),   128'(3'b001));
        check_eq("rst_io_out", 128'(io_out),    128'(mgmt_io_out));
        check_eq("rst_uin",    128'(user_io_in), 128'(0));

        // Hand pad 7 to the user project and commit
        cfg_we = 1'b1; cfg_addr = 6'd7; cfg_wdata = 13'h1800;
        step();
        cfg_we = 1'b0; cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        bcnt = int'(busy);
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            rand_io();
            cfg_we = (c == 2 || c == 3);
            cfg_addr = (c == 3) ? 6'd37 : 6'd0;
            cfg_wdata = 13'h1fff;
            step();
            bcnt += int'(busy);
            dcnt += int'(apply_done);
        end
        cfg_we = 1'b0;
        check_eq("busy_len",   128'(bcnt), 128'(P));
        check_eq("done_count", 128'(dcnt), 128'(1));
        check_eq("pad7_uin",   128'(user_io_in[7]), 128'(io_in[7]));
        check_eq("pad7_out",   128'(io_out[7]),     128'(user_io_out[7]));
        cfg_addr = 6'd0;
        #1;
        check_eq("pad0_dropped", 128'(cfg_rdata), 128'(13'h0403));

        // Out-of-range write is ignored and reads back as zero
        cfg_we = 1'b1; cfg_addr = 6'd40; cfg_wdata = 13'h1abc;
        step();
        cfg_we = 1'b0;
        #1;
        check_eq("rdata40", 128'(cfg_rdata), 128'(0));

        // Write and apply together: pad 0 switches at the first commit edge
        cfg_we = 1'b1; cfg_addr = 6'd0; cfg_wdata = 13'h1800; cfg_apply = 1'b1;
        step();
        cfg_we = 1'b0; cfg_apply = 1'b0;
        rand_io();
        step();
        check_eq("pad0_e1", 128'(io_out[0]), 128'(user_io_out[0]));
        for (int c = 0; c < 40; c++) step();

        // Reset partway through a commit aborts it without a done pulse
        cfg_we = 1'b1; cfg_addr = 6'd3; cfg_wdata = 13'h0aaa;
        step();
        cfg_we = 1'b0; cfg_apply = 1'b1;
        step();
        cfg_apply = 1'b0;
        for (int c = 0; c < 10; c++) step();
        wb_rst_i = 1'b1;
        step();
        wb_rst_i = 1'b0;
        check_eq("abort_busy", 128'(busy), 128'(0));
        check_eq("abort_oeb",  128'(oeb),  128'({P{1'b1}}));
        dcnt = 0;
        for (int c = 0; c < 45; c++) begin
            step();
            dcnt += int'(apply_done);
        end
        check_eq("abort_nodone", 128'(dcnt), 128'(0));

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            wb_rst_i  = ($urandom_range(0, 299) == 0);
            cfg_we    = ($urandom_range(0, 2) == 0);
            cfg_addr  = 6'($urandom_range(0, 45));
            cfg_wdata = 13'($urandom());
            cfg_apply = ($urandom_range(0, 49) == 0);
            rand_io();
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
